// File: rtl/traffic_timer.sv
// Interval timer for the traffic-light FSM: TS after SHORT_TICKS, TL after LONG_TICKS prescaled ticks; `TRAFFIC_TIMER_LOAD_EN adds runtime thresholds.
// Latency: TS/TL rise SHORT_TICKS*PRESCALE / LONG_TICKS*PRESCALE edges after the last edge sampling ST=1.
// Backpressure: none; ST (level) restarts and holds the timer cleared, outputs are sticky until restart.
module traffic_timer #(
    parameter int PRESCALE    = 10,
    parameter int PRE_W       = 16,
    parameter int SHORT_TICKS = 3,
    parameter int LONG_TICKS  = 8,
    parameter int CNT_W       = 8
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             ST,
`ifdef TRAFFIC_TIMER_LOAD_EN
    input  logic             ld,
    input  logic [CNT_W-1:0] ld_short,
    input  logic [CNT_W-1:0] ld_long,
`endif
    output logic             TS,
    output logic             TL
);

    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] SHORT_C = CNT_W'(SHORT_TICKS);
    localparam logic [CNT_W-1:0] LONG_C  = CNT_W'(LONG_TICKS);

    logic [PRE_W-1:0] pre;
    logic [CNT_W-1:0] elapsed;
    logic [CNT_W-1:0] elapsed_nxt;
    logic [CNT_W-1:0] short_thr;
    logic [CNT_W-1:0] long_thr;
    logic             tick;

`ifdef TRAFFIC_TIMER_LOAD_EN
    logic [CNT_W-1:0] short_q;
    logic [CNT_W-1:0] long_q;
    logic [CNT_W-1:0] short_a;
    logic [CNT_W-1:0] long_a;
    logic             ld_ok;

    assign ld_ok = ld && (ld_short != '0) && (ld_short < ld_long);

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            short_q <= SHORT_C;
            long_q  <= LONG_C;
        end else if (ld_ok) begin
            short_q <= ld_short;
            long_q  <= ld_long;
        end
    end

    // A load on the same edge as ST must govern the interval that ST starts.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            short_a <= SHORT_C;
            long_a  <= LONG_C;
        end else if (ST) begin
            short_a <= ld_ok ? ld_short : short_q;
            long_a  <= ld_ok ? ld_long  : long_q;
        end
    end

    assign short_thr = short_a;
    assign long_thr  = long_a;
`else
    assign short_thr = SHORT_C;
    assign long_thr  = LONG_C;
`endif

    always_comb begin
        tick        = (pre == PRE_MAX);
        elapsed_nxt = elapsed;
        if (tick && (elapsed < long_thr)) begin
            elapsed_nxt = elapsed + 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            pre     <= '0;
            elapsed <= '0;
            TS      <= 1'b0;
            TL      <= 1'b0;
        end else if (ST) begin
            pre     <= '0;
            elapsed <= '0;
            TS      <= 1'b0;
            TL      <= 1'b0;
        end else begin
            pre     <= tick ? '0 : pre + 1'b1;
            elapsed <= elapsed_nxt;
            TS      <= (elapsed_nxt >= short_thr);
            TL      <= (elapsed_nxt >= long_thr);
        end
    end

endmodule

// File: tb/tb_traffic_timer.sv
// Bench for traffic_timer: directed scenarios then random ST (and loads) against an edge-count model.
module tb_traffic_timer;

    localparam int P  = 2;
    localparam int SH = 3;
    localparam int LG = 8;
    localparam int CW = 8;

    logic Clk;
    logic reset;
    logic ST;
    logic TS;
    logic TL;
`ifdef TRAFFIC_TIMER_LOAD_EN
    logic          ld;
    logic [CW-1:0] ld_short;
    logic [CW-1:0] ld_long;
    int            sh_s;
    int            sh_l;
`endif

    int checks;
    int errors;
    int n;          // edges since the last restart
    int act_s;
    int act_l;

    traffic_timer #(
        .PRESCALE(P), .PRE_W(16), .SHORT_TICKS(SH), .LONG_TICKS(LG), .CNT_W(CW)
    ) dut (
        .Clk(Clk),
        .reset(reset),
        .ST(ST),
`ifdef TRAFFIC_TIMER_LOAD_EN
        .ld(ld),
        .ld_short(ld_short),
        .ld_long(ld_long),
`endif
        .TS(TS),
        .TL(TL)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk_val(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %b expected %b (t=%0t n=%0d)", tag, got, exp, $time, n);
        end
    endtask

    task automatic chk(input string tag);
        chk_val({tag, "_TS"}, TS, logic'(n >= act_s * P));
        chk_val({tag, "_TL"}, TL, logic'(n >= act_l * P));
    endtask

    // One clock edge with ST driven to st, model update, then check.
    task automatic cyc(input logic st, input string tag);
        ST = st;
        @(posedge Clk);
`ifdef TRAFFIC_TIMER_LOAD_EN
        if (ld && ld_short >= 1 && ld_short < ld_long) begin
            sh_s = int'(ld_short);
            sh_l = int'(ld_long);
        end
`endif
        if (st) begin
            n = 0;
`ifdef TRAFFIC_TIMER_LOAD_EN
            act_s = sh_s;
            act_l = sh_l;
`endif
        end else begin
            n++;
        end
        #1;
`ifdef TRAFFIC_TIMER_LOAD_EN
        ld = 1'b0;
`endif
        chk(tag);
    endtask

    task automatic model_reset();
        n     = 0;
        act_s = SH;
        act_l = LG;
`ifdef TRAFFIC_TIMER_LOAD_EN
        sh_s = SH;
        sh_l = LG;
`endif
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        ST     = 1'b0;
`ifdef TRAFFIC_TIMER_LOAD_EN
        ld       = 1'b0;
        ld_short = '0;
        ld_long  = '0;
`endif
        model_reset();

        // Reset held across edges: outputs stay low.
        repeat (3) begin
            @(posedge Clk);
            #1;
            chk_val("rst_hold_TS", TS, 1'b0);
            chk_val("rst_hold_TL", TL, 1'b0);
        end
        reset = 1'b0;
        model_reset();
        repeat (16 + 40) cyc(1'b0, "rel");

        // One-cycle ST pulse.
        cyc(1'b1, "pulse");
        repeat (20) cyc(1'b0, "pulse_run");

        // Restart at edge 10 of a running interval.
        cyc(1'b1, "mid_start");
        repeat (9) cyc(1'b0, "mid_pre");
        cyc(1'b1, "mid_restart");
        repeat (26) cyc(1'b0, "mid_run");

        // ST held high for 20 cycles.
        repeat (20) cyc(1'b1, "st_hold");
        repeat (20) cyc(1'b0, "st_fall");

        // Async reset mid-cycle after edge 9 of an interval.
        cyc(1'b1, "ar_start");
        repeat (9) cyc(1'b0, "ar_pre");
        #3;
        reset = 1'b1;
        #1;
        chk_val("async_rst_TS", TS, 1'b0);
        chk_val("async_rst_TL", TL, 1'b0);
        repeat (2) begin
            @(posedge Clk);
            #1;
            chk_val("ar_hold_TS", TS, 1'b0);
            chk_val("ar_hold_TL", TL, 1'b0);
        end
        reset = 1'b0;
        model_reset();
        repeat (20) cyc(1'b0, "ar_rel");

`ifdef TRAFFIC_TIMER_LOAD_EN
        // Mid-interval load does not affect the current interval.
        cyc(1'b1, "ld_start");
        repeat (2) cyc(1'b0, "ld_pre");
        ld = 1'b1; ld_short = 8'd2; ld_long = 8'd4;
        cyc(1'b0, "ld_mid");
        repeat (17) cyc(1'b0, "ld_cur");
        cyc(1'b1, "ld_new");
        repeat (10) cyc(1'b0, "ld_new_run");
        // Illegal load is ignored.
        ld = 1'b1; ld_short = 8'd5; ld_long = 8'd5;
        cyc(1'b0, "ld_bad");
        cyc(1'b1, "ld_bad_restart");
        repeat (10) cyc(1'b0, "ld_bad_run");
        // Load and ST on the same edge.
        ld = 1'b1; ld_short = 8'd1; ld_long = 8'd6;
        cyc(1'b1, "ld_same");
        repeat (14) cyc(1'b0, "ld_same_run");
`endif

        // Random ST pulses/holds (and loads when available).
        for (int i = 0; i < 600; i++) begin
`ifdef TRAFFIC_TIMER_LOAD_EN
            if ($urandom_range(0, 15) == 0) begin
                ld       = 1'b1;
                ld_short = CW'($urandom_range(0, 10));
                ld_long  = CW'($urandom_range(0, 12));
            end
`endif
            cyc(logic'($urandom_range(0, 24) == 0), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_timer.md
Name: traffic_timer

Overview:
- Interval timer feeding the traffic-light controller FSM.
- Consumes the FSM's start-timer strobe ST and produces the short-interval-expired flag TS and the long-interval-expired flag TL that the FSM uses to time green/yellow phases.
- Contains a clock prescaler and a saturating tick counter.
- Sits directly beside the FSM in the top level, on the same Clk and reset.

Parameters:
- PRESCALE, 10: Clk cycles per timer tick. Legal range 1..2^PRE_W-1.
- PRE_W, 16: prescaler counter width.
- SHORT_TICKS, 3: ticks until TS asserts. Must be >=1.
- LONG_TICKS, 8: ticks until TL asserts. Must be > SHORT_TICKS.
- CNT_W, 8: elapsed-tick counter width. Must hold LONG_TICKS.

Ports:
- Clk, input, 1: system clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- ST, input, 1: start/restart timer, level-sensitive, driven by the FSM.
- TS, output, 1: short interval elapsed; registered, sticky until restart.
- TL, output, 1: long interval elapsed; registered, sticky until restart.

Behaviour:
- Registers: pre (PRE_W bits), elapsed (CNT_W bits), TS, TL. All are clocked on rising Clk.
- Reset (async, active-high):
  - pre=0, elapsed=0, TS=0, TL=0 immediately.
  - Counting begins on the first rising edge with reset low, exactly as if ST had been sampled high at reset release.
- Restart:
  - Any edge sampling ST=1 loads pre=0, elapsed=0, TS=0, TL=0.
  - ST held high keeps the timer frozen in this cleared state.
  - ST has priority over a tick in the same cycle.
- Prescaler:
  - With ST=0, pre increments each edge.
  - tick = (pre == PRESCALE-1). When tick, pre wraps to 0.
  - PRESCALE=1 gives tick every cycle with pre stuck at 0.
- Elapsed counter:
  - On tick with ST=0, elapsed increments if elapsed < LONG_TICKS.
  - It saturates at LONG_TICKS. No wrap, ever.
  - Once saturated, pre continues free-running; this has no effect on outputs.
- Outputs:
  - On the same edge elapsed is updated, TS <= (elapsed_next >= SHORT_TICKS) and TL <= (elapsed_next >= LONG_TICKS).
  - TS and TL are monotonic between restarts: once high, they stay high until ST or reset.
- Latency, measured from the last edge sampling ST=1, called edge 0:
  - TS rises at edge SHORT_TICKS*PRESCALE.
  - TL rises at edge LONG_TICKS*PRESCALE.
  - No combinational path from ST to TS/TL.
- TL=1 always implies TS=1.
- Reset asserted mid-interval clears all state immediately regardless of Clk.
- A one-cycle ST pulse mid-interval fully restarts the interval, with no residual prescaler phase.

Optional Feature:
- Macro: TRAFFIC_TIMER_LOAD_EN.
- When defined, adds ports:
  - ld, input, 1
  - ld_short, input, CNT_W
  - ld_long, input, CNT_W
- Shadow registers short_q and long_q:
  - Reset to SHORT_TICKS and LONG_TICKS.
  - Capture ld_short and ld_long on an edge sampling ld=1, only if ld_short>=1 and ld_short<ld_long. Otherwise the load is ignored and the old values are kept.
- Active thresholds:
  - Copied from the shadows on every restart (ST=1 edge or reset release).
  - A load mid-interval never alters the current interval.
  - If ld and ST occur on the same edge, the newly loaded values take effect for the interval started by that ST.
- When undefined: no extra ports, and the thresholds are the constant parameters.

Test Plan (PRESCALE=2, SHORT_TICKS=3, LONG_TICKS=8 unless noted):
- Reset held, then released with ST=0 -> TS=0 and TL=0 during reset; TS rises at edge 6 after release; TL rises at edge 16; both remain 1 for 40 further cycles.
- ST pulsed 1 cycle at edge 0 -> TS=0 through edge 5 and 1 at edge 6; TL=0 through edge 15 and 1 at edge 16.
- ST pulsed at edge 10 of a running interval (TS already 1) -> TS and TL cleared at edge 10; TS re-rises at edge 16; TL re-rises at edge 26.
- ST held high for 20 cycles -> TS=TL=0 throughout; after ST falls, TS rises exactly 6 edges after the last ST=1 edge.
- Reset asserted asynchronously mid-cycle at edge 9 -> TS=TL=0 immediately without waiting for Clk; counting restarts from release.
- Macro defined:
  - ld with ld_short=2, ld_long=4 at edge 3 mid-interval -> current interval still gives TS at edge 6 and TL at edge 16.
  - After the next ST, TS rises at +4 and TL at +8.
  - ld with ld_short=5, ld_long=5 -> ignored.
